// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-ported data memory between the CPU MEM stage (A) and a DMA master (B).
// Latency: grants and memory-side signals are combinational in the request cycle; load data same cycle.
// Backpressure: nothing is buffered; an ungranted requester holds req/payload, a_stall freezes the CPU.
module dm_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wd,
  input  logic [31:0]   a_pc,
  output logic          a_gnt,
  output logic          a_stall,
  output logic [DW-1:0] a_rd,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wd,
  output logic          b_gnt,
  output logic [DW-1:0] b_rd,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wd,
  output logic [31:0]   m_pc,
  input  logic [DW-1:0] m_rd
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

  owner_t        r_owner;
  owner_t        w_owner_nxt;
  logic [HW-1:0] r_hold;
  logic [HW-1:0] w_hold_nxt;
  logic          w_both;
  logic          w_gnt_a;
  logic          w_gnt_b;

  // Arbitration state register: current owner and its consecutive contended-grant count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= OWN_A;
      r_hold  <= '0;
    end else begin
      r_owner <= w_owner_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // Same-cycle grant decision and next arbitration state; reset suppresses every grant
  always_comb begin
    w_gnt_a     = 1'b0;
    w_gnt_b     = 1'b0;
    w_owner_nxt = r_owner;
    w_hold_nxt  = r_hold;
    w_both      = a_req & b_req;
    if (!reset) begin
      if (w_both) begin
        if (r_hold == HOLD_MAX) begin
          // Owner has used up its streak: hand over so the other side waits at most MAX_HOLD
          w_gnt_a     = (r_owner == OWN_B);
          w_gnt_b     = (r_owner == OWN_A);
          w_owner_nxt = (r_owner == OWN_A) ? OWN_B : OWN_A;
          w_hold_nxt  = HOLD_ONE;
        end else begin
          // r_hold < HOLD_MAX here, so the increment never wraps
          w_gnt_a    = (r_owner == OWN_A);
          w_gnt_b    = (r_owner == OWN_B);
          w_hold_nxt = r_hold + 1'b1;
        end
      end else if (a_req) begin
        w_gnt_a     = 1'b1;
        w_owner_nxt = OWN_A;
        w_hold_nxt  = '0;
      end else if (b_req) begin
        w_gnt_b     = 1'b1;
        w_owner_nxt = OWN_B;
        w_hold_nxt  = '0;
      end
    end
  end

  // Memory-side mux from the granted port; idle drives zeros so the trace stays quiet
  always_comb begin
    m_we   = 1'b0;
    m_addr = '0;
    m_wd   = '0;
    m_pc   = '0;
    if (w_gnt_a) begin
      m_we   = a_we;
      m_addr = a_addr;
      m_wd   = a_wd;
      m_pc   = a_pc;
    end else if (w_gnt_b) begin
      m_we   = b_we;
      m_addr = b_addr;
      m_wd   = b_wd;
    end
  end

  assign a_gnt   = w_gnt_a;
  assign b_gnt   = w_gnt_b;
  assign a_stall = a_req & ~w_gnt_a;
  assign a_rd    = m_rd;
  assign b_rd    = m_rd;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed and random stimulus for dm_arbiter against a streak-count reference model.
// Inputs change 1 time unit after posedge; outputs are compared on the negedge.
// Memory writes are captured on the negedge and applied on the next posedge.
module tb_dm_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MH = 4;

  logic          clk    = 1'b0;
  logic          reset  = 1'b1;
  logic          a_req  = 1'b0;
  logic          a_we   = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wd   = '0;
  logic [31:0]   a_pc   = '0;
  logic          b_req  = 1'b0;
  logic          b_we   = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wd   = '0;
  logic          a_gnt, a_stall, b_gnt, m_we;
  logic [DW-1:0] a_rd, b_rd, m_wd, m_rd;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wd(a_wd), .a_pc(a_pc),
    .a_gnt(a_gnt), .a_stall(a_stall), .a_rd(a_rd),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wd(b_wd),
    .b_gnt(b_gnt), .b_rd(b_rd),
    .m_we(m_we), .m_addr(m_addr), .m_wd(m_wd), .m_pc(m_pc), .m_rd(m_rd)
  );

  // Stand-in data memory driven by the DUT, and the reference copy driven by the model
  logic [DW-1:0] dm      [0:1023];
  logic [DW-1:0] ref_mem [0:1023];
  assign m_rd = dm[m_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who got the last grant, and how long its contended streak is
  int   m_last = 0;   // 0 = A, 1 = B
  int   m_run  = 0;
  int   wa = 0, wb = 0;
  bit   a_g_seen = 0, b_g_seen = 0;
  bit   p_rst, p_ga, p_gb, p_both;
  bit   d_we, e_we;
  logic [AW-1:0] d_addr, e_addr;
  logic [DW-1:0] d_wd, e_wd;

  always @(negedge clk) begin
    bit ga, gb;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_wd;
    logic [31:0]   x_pc;
    bit            x_we;
    ga = 0; gb = 0;
    if (!reset) begin
      if (a_req && b_req) begin
        if (m_run >= MH) begin ga = (m_last == 1); gb = (m_last == 0); end
        else             begin ga = (m_last == 0); gb = (m_last == 1); end
      end else begin
        ga = a_req; gb = b_req;
      end
    end
    x_we = 0; x_addr = '0; x_wd = '0; x_pc = '0;
    if (ga) begin x_we = a_we; x_addr = a_addr; x_wd = a_wd; x_pc = a_pc; end
    if (gb) begin x_we = b_we; x_addr = b_addr; x_wd = b_wd; end
    check("a_gnt",   a_gnt,   ga);
    check("b_gnt",   b_gnt,   gb);
    check("a_stall", a_stall, a_req & ~ga);
    check("m_we",    m_we,    x_we);
    check("m_addr",  m_addr,  x_addr);
    check("m_wd",    m_wd,    x_wd);
    check("m_pc",    m_pc,    x_pc);
    if (ga && !a_we) check("a_rd", a_rd, ref_mem[a_addr]);
    if (gb && !b_we) check("b_rd", b_rd, ref_mem[b_addr]);
    // starvation bound observed on the DUT's own grants
    if (a_req && !a_gnt && !reset) wa++; else wa = 0;
    if (b_req && !b_gnt && !reset) wb++; else wb = 0;
    if (a_req && !reset) check("a_wait_le_max", wa <= MH, 1'b1);
    if (b_req && !reset) check("b_wait_le_max", wb <= MH, 1'b1);
    a_g_seen = a_gnt; b_g_seen = b_gnt;
    p_rst = reset; p_ga = ga; p_gb = gb; p_both = a_req && b_req;
    d_we = m_we; d_addr = m_addr; d_wd = m_wd;
    e_we = x_we; e_addr = x_addr; e_wd = x_wd;
  end

  always @(posedge clk) begin
    if (d_we) dm[d_addr] <= d_wd;
    if (e_we) ref_mem[e_addr] <= e_wd;
    if (p_rst) begin
      m_last <= 0; m_run <= 0;
    end else if (p_ga || p_gb) begin
      if (!p_both) begin
        m_last <= int'(p_gb); m_run <= 0;
      end else if (int'(p_gb) == m_last) begin
        m_run <= m_run + 1;
      end else begin
        m_last <= int'(p_gb); m_run <= 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return '1;
    return AW'($urandom_range(0, 15));
  endfunction

  bit pat [12] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};

  initial begin
    for (int i = 0; i < 1024; i++) begin
      dm[i]      = DW'(i * 7 + 3);
      ref_mem[i] = DW'(i * 7 + 3);
    end
    // 1: reset two cycles, idle
    reset = 1'b1;
    tick(); tick();
    check("rst_a_gnt", a_gnt, 1'b0);
    check("rst_b_gnt", b_gnt, 1'b0);
    check("rst_m_we",  m_we,  1'b0);
    reset = 1'b0;
    // 2: lone A store
    a_req = 1; a_we = 1; a_addr = 10'h004; a_wd = 32'hDEADBEEF; a_pc = 32'h3008;
    #1;
    check("t2_a_gnt",  a_gnt,  1'b1);
    check("t2_m_we",   m_we,   1'b1);
    check("t2_m_addr", m_addr, 10'h004);
    check("t2_m_wd",   m_wd,   32'hDEADBEEF);
    check("t2_m_pc",   m_pc,   32'h3008);
    tick();
    // 3: both request continuously -> 4 A, 4 B, then A again
    a_we = 0; a_addr = 10'h004; b_req = 1; b_we = 0; b_addr = 10'h010;
    for (int i = 0; i < 12; i++) begin
      #1;
      check("t3_a_gnt",   a_gnt,   pat[i]);
      check("t3_b_gnt",   b_gnt,   !pat[i]);
      check("t3_a_stall", a_stall, !pat[i]);
      if (pat[i]) check("t3_a_rd", a_rd, 32'hDEADBEEF);
      tick();
    end
    // 4: B writes 3FF, then A reads it back
    a_req = 0; b_req = 1; b_we = 1; b_addr = 10'h3FF; b_wd = 32'h1;
    #1;
    check("t4_b_gnt",  b_gnt,  1'b1);
    check("t4_m_addr", m_addr, 10'h3FF);
    check("t4_m_pc",   m_pc,   32'h0);
    tick();
    b_req = 0; a_req = 1; a_we = 0; a_addr = 10'h3FF;
    #1;
    check("t4_a_gnt", a_gnt, 1'b1);
    check("t4_a_rd",  a_rd,  32'h1);
    tick();
    // 5: contention up to hold 3, then one reset cycle
    b_req = 1; b_we = 0; b_addr = 10'h020;
    tick(); tick(); tick();
    reset = 1; a_we = 1; b_we = 1;
    #1;
    check("t5_a_gnt",   a_gnt,   1'b0);
    check("t5_b_gnt",   b_gnt,   1'b0);
    check("t5_m_we",    m_we,    1'b0);
    check("t5_a_stall", a_stall, 1'b1);
    tick();
    reset = 0; a_we = 0; b_we = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t5_post_a_gnt", a_gnt, i < 4);
      tick();
    end
    a_req = 0; b_req = 0;
    tick();
    // 6: random traffic, requests held until granted
    for (int n = 0; n < 10000; n++) begin
      if (!a_req || a_g_seen) begin
        a_req = ($urandom_range(0, 3) != 0); a_we = 1'($urandom_range(0, 1));
        a_addr = rand_addr(); a_wd = $urandom; a_pc = $urandom;
      end
      if (!b_req || b_g_seen) begin
        b_req = ($urandom_range(0, 3) != 0); b_we = 1'($urandom_range(0, 1));
        b_addr = rand_addr(); b_wd = $urandom;
      end
      tick();
    end
    a_req = 0; b_req = 0;
    tick(); tick();
    for (int i = 0; i < 1024; i++) check("mem_contents", dm[i], ref_mem[i]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
